motor_encoder: RTL and testbench
================================

MOTOR_ENCODER -- requirements
Module: motor_encoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the signed position counter.
REQ-002 Parameter SPD_W, default 16: width of the speed measurement.
REQ-003 Parameter WINDOW, default 50000: speed sample window length in cin cycles, minimum 2.
REQ-004 cin  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  1 = counting active; 0 = position and speed state frozen.
REQ-007 enc_a  input  1  quadrature channel A, asynchronous to cin.
REQ-008 enc_b  input  1  quadrature channel B, asynchronous to cin.
REQ-009 clear_pos  input  1  synchronous clear of position and err.
REQ-010 position  output  CNT_W  signed two's-complement step count.
REQ-011 dir  output  1  last valid step direction: 1 forward, 0 backward (same convention as the motor PWM dir input).
REQ-012 speed  output  SPD_W  unsigned count of valid steps in the last completed window.
REQ-013 speed_valid  output  1  one-cycle pulse when speed is updated.
REQ-014 err  output  1  sticky flag: illegal quadrature transition detected.

Function
REQ-015 The block SHALL pass enc_a and enc_b each through a 2-flop synchronizer, then compare the synchronized pair {A,B} against its value from the previous cycle.
REQ-016 Forward sequence {A,B}: 00->10->11->01->00; backward is the reverse; each single-bit transition is one step (4x decoding).
REQ-017 Forward step: position +1, dir <= 1; backward step: position -1, dir <= 0; no change: position and dir hold.
REQ-018 Both bits changing in one cycle: no position change, dir holds, err <= 1.
REQ-019 Position wraps modulo 2^CNT_W in both directions (max positive +1 -> min negative, and vice versa), without flagging err.
REQ-020 Latency: a change on enc_a/enc_b sampled at rising edge k SHALL be reflected in position/dir after rising edge k+2.
REQ-021 The block SHALL implement states FILL and RUN; after reset it stays in FILL for exactly 2 cycles (synchronizer filling, no decoding, no err), then enters RUN permanently until the next reset.
REQ-022 Speed: a window counter runs 0..WINDOW-1 continuously in RUN while enable=1; a step counter increments on every valid step of either direction, saturating at 2^SPD_W-1.
REQ-023 In the cycle the window counter equals WINDOW-1, speed <= step count including any step in that cycle, speed_valid <= 1, and both counters restart at 0.
REQ-024 enable=0: position, dir, window counter, step counter, speed hold; speed_valid = 0; synchronizers and the previous-sample register keep tracking, so no step is counted for motion during disable.
REQ-025 clear_pos=1: position <= 0 and err <= 0 on that edge; clear wins over a simultaneous step or illegal transition; dir and speed logic are unaffected.
REQ-026 err SHALL only be cleared by clear_pos or reset.

Reset
REQ-027 On rising cin with rst_n=0: position=0, dir=1, speed=0, speed_valid=0, err=0, synchronizers and previous sample=00, counters=0, state=FILL.
REQ-028 Reset mid-window SHALL discard the partial window; reset has priority over enable and clear_pos.

Structure
REQ-029 Shared package motor_pkg holds DIR_FWD=1, DIR_BWD=0 and the step-classification enum STEP_NONE/STEP_FWD/STEP_BWD/STEP_ERR.
REQ-030 One sub-module, quad_step_decode: synchronizers, previous-sample register and step classification; top level holds position, speed and the FILL/RUN state.

Verification
REQ-031 Reset, then 8 forward steps (00,10,11,01,00,...) spaced 4 cycles apart -> position=8, dir=1, err=0; each update 2 edges after first sample.
REQ-032 position=0, 3 backward steps -> position=-3 (0xFFFD at CNT_W=16), dir=0.
REQ-033 WINDOW=10, one forward step every 2 cycles -> speed_valid pulses every 10 cycles, speed=5.
REQ-034 Inject 00->11 -> err=1, position unchanged; assert clear_pos together with a valid step -> position=0, err=0.
REQ-035 enable=0 during 4 forward steps, then enable=1 -> position unchanged, no err, window counter resumes from held value.
REQ-036 Release reset with enc_a=enc_b=1 held -> no err, no step, first speed_valid after WINDOW cycles in RUN with speed=0.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared encoder definitions: direction encoding, step classes, FSM states
// and the quadrature phase helper used by the step decoder.
package motor_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BWD  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_t;

  // Position of {A,B} along the forward cycle 00->10->11->01; a +1 phase
  // difference (mod 4) is a forward step, -1 backward, 2 both bits flipped.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b10:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/quad_step_decode.sv
// Synchronizes the asynchronous quadrature pair and classifies each cycle's
// change against the previous synchronized sample.
module quad_step_decode
  import motor_pkg::*;
(
  input  logic  cin,
  input  logic  rst_n,
  input  logic  i_enc_a,
  input  logic  i_enc_b,
  input  logic  i_fill,
  output step_t o_step
);

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;
  logic [1:0] w_delta;

  // While filling, prev follows the first stage so that it equals the second
  // stage on entry to RUN; a level held through reset never looks like motion.
  always_ff @(posedge cin) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= {i_enc_a, i_enc_b};
      r_sync2 <= r_sync1;
      r_prev  <= i_fill ? r_sync1 : r_sync2;
    end
  end

  always_comb begin
    w_delta = quad_phase(r_sync2) - quad_phase(r_prev);
    o_step  = STEP_NONE;
    if (!i_fill) begin
      case (w_delta)
        2'd1:    o_step = STEP_FWD;
        2'd3:    o_step = STEP_BWD;
        2'd2:    o_step = STEP_ERR;
        default: o_step = STEP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/motor_encoder.sv
// Quadrature encoder interface: 4x-decoded signed position, direction,
// sticky illegal-transition flag and windowed step-rate measurement.
module motor_encoder
  import motor_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int SPD_W  = 16,
  parameter int WINDOW = 50000
) (
  input  logic                    cin,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    clear_pos,
  output logic signed [CNT_W-1:0] position,
  output logic                    dir,
  output logic        [SPD_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    err
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  enc_state_t r_state, w_state_nxt;
  logic       r_fill_cnt, w_fill_cnt_nxt;

  logic [CNT_W-1:0] r_position;
  logic             r_dir;
  logic             r_err;
  logic [SPD_W-1:0] r_speed;
  logic             r_speed_valid;
  logic [WIN_W-1:0] r_win_cnt;
  logic [SPD_W-1:0] r_step_cnt;

  step_t            w_step;
  logic             w_fill;
  logic             w_active;
  logic             w_fwd;
  logic             w_bwd;
  logic             w_ill;
  logic [SPD_W-1:0] w_step_sat;

  assign w_fill = (r_state == ST_FILL);

  quad_step_decode u_dec (
    .cin     (cin),
    .rst_n   (rst_n),
    .i_enc_a (enc_a),
    .i_enc_b (enc_b),
    .i_fill  (w_fill),
    .o_step  (w_step)
  );

  always_ff @(posedge cin) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
    end
  end

  // Two FILL cycles let the synchronizer settle; RUN is then permanent.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    case (r_state)
      ST_FILL: begin
        w_fill_cnt_nxt = 1'b1;
        if (r_fill_cnt) w_state_nxt = ST_RUN;
      end
      ST_RUN: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_active = (r_state == ST_RUN) && enable;
  assign w_fwd    = w_active && (w_step == STEP_FWD);
  assign w_bwd    = w_active && (w_step == STEP_BWD);
  assign w_ill    = w_active && (w_step == STEP_ERR);

  assign w_step_sat = ((w_fwd || w_bwd) && (r_step_cnt != '1)) ?
                      r_step_cnt + SPD_W'(1) : r_step_cnt;

  always_ff @(posedge cin) begin
    if (!rst_n) begin
      r_position <= '0;
      r_dir      <= DIR_FWD;
      r_err      <= 1'b0;
    end else begin
      if (clear_pos)  r_position <= '0;
      else if (w_fwd) r_position <= r_position + CNT_W'(1);
      else if (w_bwd) r_position <= r_position - CNT_W'(1);

      if (w_fwd)      r_dir <= DIR_FWD;
      else if (w_bwd) r_dir <= DIR_BWD;

      if (clear_pos)  r_err <= 1'b0;
      else if (w_ill) r_err <= 1'b1;
    end
  end

  // A step landing on the last window cycle is counted into that window.
  always_ff @(posedge cin) begin
    if (!rst_n) begin
      r_win_cnt     <= '0;
      r_step_cnt    <= '0;
      r_speed       <= '0;
      r_speed_valid <= 1'b0;
    end else begin
      r_speed_valid <= 1'b0;
      if (w_active) begin
        if (r_win_cnt == WIN_LAST) begin
          r_win_cnt     <= '0;
          r_step_cnt    <= '0;
          r_speed       <= w_step_sat;
          r_speed_valid <= 1'b1;
        end else begin
          r_win_cnt  <= r_win_cnt + WIN_W'(1);
          r_step_cnt <= w_step_sat;
        end
      end
    end
  end

  assign position    = r_position;
  assign dir         = r_dir;
  assign err         = r_err;
  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;

endmodule

// File: tb/tb_motor_encoder.sv
// Random and directed stimulus against a phase-history model of the encoder;
// every cycle all outputs are compared to the model.
module tb_motor_encoder;

  localparam int CNT_W  = 8;
  localparam int SPD_W  = 3;
  localparam int WINDOW = 10;
  localparam int PMASK  = (1 << CNT_W) - 1;
  localparam int SMAX   = (1 << SPD_W) - 1;

  logic cin = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, enc_a = 1'b0, enc_b = 1'b0, clear_pos = 1'b0;
  logic signed [CNT_W-1:0] position;
  logic                    dir;
  logic        [SPD_W-1:0] speed;
  logic                    speed_valid;
  logic                    err;

  int errors = 0;
  int checks = 0;

  int ph = 0;
  int hist[$];
  int m_pos, m_dir, m_err, m_spd, m_sv, m_win, m_stp;

  motor_encoder #(.CNT_W(CNT_W), .SPD_W(SPD_W), .WINDOW(WINDOW)) dut (
    .cin         (cin),
    .rst_n       (rst_n),
    .enable      (enable),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .clear_pos   (clear_pos),
    .position    (position),
    .dir         (dir),
    .speed       (speed),
    .speed_valid (speed_valid),
    .err         (err)
  );

  always #5 cin = ~cin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic set_ph(input int p);
    ph = p & 3;
    case (ph)
      0: {enc_a, enc_b} = 2'b00;
      1: {enc_a, enc_b} = 2'b10;
      2: {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b01;
    endcase
  endtask

  // Each edge's sampled phase is visible to the decoder two edges later; the
  // first two edges after reset only fill the synchronizer.
  task automatic model_update();
    int n, d, st;
    if (!rst_n) begin
      m_pos = 0; m_dir = 1; m_err = 0; m_spd = 0; m_sv = 0; m_win = 0; m_stp = 0;
      hist.delete();
      return;
    end
    hist.push_back(ph);
    n = hist.size();
    m_sv = 0;
    if (n >= 3 && enable) begin
      d = 0;
      if (n >= 4) d = (hist[n-3] - hist[n-4]) & 3;
      if (d == 1) begin m_pos = (m_pos + 1) & PMASK; m_dir = 1; end
      else if (d == 3) begin m_pos = (m_pos + PMASK) & PMASK; m_dir = 0; end
      else if (d == 2) m_err = 1;
      st = m_stp + ((d == 1 || d == 3) ? 1 : 0);
      if (st > SMAX) st = SMAX;
      if (m_win == WINDOW - 1) begin
        m_spd = st; m_sv = 1; m_win = 0; m_stp = 0;
      end else begin
        m_win++; m_stp = st;
      end
    end
    if (clear_pos) begin m_pos = 0; m_err = 0; end
  endtask

  task automatic cyc();
    @(posedge cin);
    model_update();
    #1;
    check("position",    32'($unsigned(position)), m_pos);
    check("dir",         32'(dir), m_dir);
    check("err",         32'(err), m_err);
    check("speed",       32'(speed), m_spd);
    check("speed_valid", 32'(speed_valid), m_sv);
  endtask

  initial begin
    int r;
    // reset and settle
    set_ph(0);
    repeat (3) cyc();
    rst_n = 1'b1; enable = 1'b1;
    repeat (4) cyc();

    // 8 forward steps, 4 cycles apart
    for (int i = 0; i < 8; i++) begin set_ph(ph + 1); repeat (4) cyc(); end
    check("fwd8_pos", 32'($unsigned(position)), 8);
    check("fwd8_dir", 32'(dir), 1);

    // clear, then 3 backward steps
    clear_pos = 1'b1; cyc(); clear_pos = 1'b0;
    for (int i = 0; i < 3; i++) begin set_ph(ph - 1); repeat (4) cyc(); end
    check("bwd3_pos", 32'($unsigned(position)), 32'hFD);
    check("bwd3_dir", 32'(dir), 0);

    // forward step every 2 cycles: 5 steps per window
    for (int i = 0; i < 20; i++) begin set_ph(ph + 1); repeat (2) cyc(); end
    check("speed5", 32'(speed), 5);

    // illegal double change, then clear together with a valid step
    set_ph(ph + 2); repeat (4) cyc();
    check("illegal_err", 32'(err), 1);
    set_ph(ph + 1); cyc(); cyc();
    clear_pos = 1'b1; cyc(); clear_pos = 1'b0;
    cyc();
    check("clear_pos", 32'($unsigned(position)), 0);
    check("clear_err", 32'(err), 0);

    // motion while disabled is not counted
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin set_ph(ph + 1); repeat (3) cyc(); end
    repeat (3) cyc();
    enable = 1'b1;
    repeat (25) cyc();

    // continuous forward motion: wraps position, saturates speed
    for (int i = 0; i < 300; i++) begin set_ph(ph + 1); cyc(); end
    check("speed_sat", 32'(speed), SMAX);

    // randomized motion, enable, clear and occasional reset
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) set_ph(ph + 1);
      else if (r < 60) set_ph(ph - 1);
      else if (r < 63) set_ph(ph + 2);
      enable    = ($urandom_range(0, 9) != 0);
      clear_pos = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1; enable = 1'b1; clear_pos = 1'b0;
    repeat (5) cyc();

    // reset mid-window released with both channels high
    set_ph(2); rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (WINDOW + 5) cyc();
    check("hold11_err", 32'(err), 0);
    check("hold11_pos", 32'($unsigned(position)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
